// File: rtl/uart_piso_frame_if.sv
// Bus between the TX control logic and the UART frame serialiser.
interface uart_piso_frame_if #(
    parameter int unsigned MAX_DATA_BITS = 9
);
    logic [MAX_DATA_BITS-1:0] data_in;
    logic [3:0]               data_len;
    logic [2:0]               parity_type;
    logic                     stop_bits;
    logic                     send;
    logic                     tx_ready;
    logic                     data_out;
    logic                     p_parity_out;
    logic                     tx_active;
    logic                     tx_done;

    modport master (
        output data_in, data_len, parity_type, stop_bits, send,
        input  tx_ready, data_out, p_parity_out, tx_active, tx_done
    );

    modport slave (
        input  data_in, data_len, parity_type, stop_bits, send,
        output tx_ready, data_out, p_parity_out, tx_active, tx_done
    );
endinterface

// File: rtl/uart_piso_frame.sv
// UART transmit serialiser: one-frame holding buffer feeding a start/data/parity/stop
// shift stage. Clocked by the baud generator, one edge per bit period.
module uart_piso_frame #(
    parameter int unsigned MAX_DATA_BITS = 9
) (
    input logic               BaudOut,
    input logic               rst,
    uart_piso_frame_if.slave  bus
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} stateT;

    localparam logic [3:0] MaxLen = 4'(MAX_DATA_BITS);

    // Holding stage
    logic [MAX_DATA_BITS-1:0] holdDataQ, holdDataD;
    logic [3:0]               holdLenQ, holdLenD;
    logic [2:0]               holdParQ, holdParD;
    logic                     holdStop2Q, holdStop2D;
    logic                     holdFullQ, holdFullD;

    // Shift stage
    stateT                    stateQ, stateD;
    logic [MAX_DATA_BITS-1:0] shiftQ, shiftD;
    logic [3:0]               bitCntQ, bitCntD;
    logic [3:0]               lenQ, lenD;
    logic                     parEnQ, parEnD;
    logic                     parQ, parD;
    logic                     stop2Q, stop2D;
    logic                     lineQ, lineD;
    logic                     doneQ, doneD;

    logic                     load;
    logic [3:0]               lenClamp;
    logic [MAX_DATA_BITS-1:0] holdMasked;
    logic                     holdParEn;
    logic                     holdParBit;

    // Clamp the requested data length into 5..MAX_DATA_BITS
    always_comb begin
        lenClamp = bus.data_len;
        if (bus.data_len < 4'd5) begin
            lenClamp = 4'd5;
        end else if (bus.data_len > MaxLen) begin
            lenClamp = MaxLen;
        end
    end

    // Parity of the queued frame, over its N data bits only
    always_comb begin
        holdMasked = '0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            holdMasked[i] = holdDataQ[i] & (4'(i) < holdLenQ);
        end
        holdParEn  = 1'b0;
        holdParBit = 1'b0;
        case (holdParQ)
            3'd1: begin holdParEn = 1'b1; holdParBit = ~^holdMasked; end
            3'd2: begin holdParEn = 1'b1; holdParBit = ^holdMasked;  end
            3'd3: begin holdParEn = 1'b1; holdParBit = 1'b1;         end
            3'd4: begin holdParEn = 1'b1; holdParBit = 1'b0;         end
            default: ;
        endcase
    end

    // Shift-stage FSM; lineD is the level the line takes in the next bit period
    always_comb begin
        stateD = stateQ;
        shiftD = shiftQ;
        bitCntD = bitCntQ;
        lenD = lenQ;
        parEnD = parEnQ;
        parD = parQ;
        stop2D = stop2Q;
        lineD = lineQ;
        doneD = 1'b0;
        load = 1'b0;
        unique case (stateQ)
            StIdle: begin
                lineD = 1'b1;
                if (holdFullQ) load = 1'b1;
            end
            StStart: begin
                stateD = StData;
                bitCntD = 4'd0;
                lineD = shiftQ[0];
            end
            StData: begin
                if (bitCntQ == lenQ - 4'd1) begin
                    bitCntD = 4'd0;
                    if (parEnQ) begin
                        stateD = StParity;
                        lineD = parQ;
                    end else begin
                        stateD = StStop;
                        lineD = 1'b1;
                    end
                end else begin
                    shiftD = shiftQ >> 1;
                    bitCntD = bitCntQ + 4'd1;
                    lineD = shiftQ[1];
                end
            end
            StParity: begin
                stateD = StStop;
                bitCntD = 4'd0;
                lineD = 1'b1;
            end
            StStop: begin
                if (bitCntQ == {3'b000, stop2Q}) begin
                    doneD = 1'b1;
                    if (holdFullQ) begin
                        load = 1'b1;
                    end else begin
                        stateD = StIdle;
                        lineD = 1'b1;
                        parD = 1'b0;
                    end
                end else begin
                    bitCntD = bitCntQ + 4'd1;
                    lineD = 1'b1;
                end
            end
            default: begin
                stateD = StIdle;
                lineD = 1'b1;
                parD = 1'b0;
            end
        endcase
        // Transfer from holding: the new start bit goes out at this same edge
        if (load) begin
            stateD = StStart;
            shiftD = holdDataQ;
            lenD = holdLenQ;
            parEnD = holdParEn;
            parD = holdParBit;
            stop2D = holdStop2Q;
            bitCntD = 4'd0;
            lineD = 1'b0;
        end
    end

    // Holding register: transfer empties it, accept fills it (never both in one cycle)
    always_comb begin
        holdDataD = holdDataQ;
        holdLenD = holdLenQ;
        holdParD = holdParQ;
        holdStop2D = holdStop2Q;
        holdFullD = holdFullQ;
        if (load) begin
            holdFullD = 1'b0;
        end else if (bus.send && !holdFullQ) begin
            holdDataD = bus.data_in;
            holdLenD = lenClamp;
            holdParD = bus.parity_type;
            holdStop2D = bus.stop_bits;
            holdFullD = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge BaudOut) begin
        if (rst) begin
            holdDataQ <= '0;
            holdLenQ <= 4'd0;
            holdParQ <= 3'd0;
            holdStop2Q <= 1'b0;
            holdFullQ <= 1'b0;
            stateQ <= StIdle;
            shiftQ <= '0;
            bitCntQ <= 4'd0;
            lenQ <= 4'd0;
            parEnQ <= 1'b0;
            parQ <= 1'b0;
            stop2Q <= 1'b0;
            lineQ <= 1'b1;
            doneQ <= 1'b0;
        end else begin
            holdDataQ <= holdDataD;
            holdLenQ <= holdLenD;
            holdParQ <= holdParD;
            holdStop2Q <= holdStop2D;
            holdFullQ <= holdFullD;
            stateQ <= stateD;
            shiftQ <= shiftD;
            bitCntQ <= bitCntD;
            lenQ <= lenD;
            parEnQ <= parEnD;
            parQ <= parD;
            stop2Q <= stop2D;
            lineQ <= lineD;
            doneQ <= doneD;
        end
    end

    assign bus.tx_ready = ~holdFullQ;
    assign bus.data_out = lineQ;
    assign bus.p_parity_out = parQ;
    assign bus.tx_active = (stateQ != StIdle);
    assign bus.tx_done = doneQ;

endmodule

// File: tb/tb_uart_piso_frame.sv
// Directed bench for uart_piso_frame: table of single frames plus hand-written
// back-to-back and mid-frame reset sequences.
module tb_uart_piso_frame;

    logic BaudOut;
    logic rst;
    int   checks;
    int   errors;

    uart_piso_frame_if #(.MAX_DATA_BITS(9)) bus ();

    uart_piso_frame #(.MAX_DATA_BITS(9)) dut (
        .BaudOut (BaudOut),
        .rst     (rst),
        .bus     (bus.slave)
    );

    initial BaudOut = 1'b0;
    always #5 BaudOut = ~BaudOut;

    typedef struct {
        string      name;
        logic [8:0] data;
        logic [3:0] len;
        logic [2:0] par;
        logic       stop;
        int         flen;
        logic [15:0] bits;   // bit k = line level k periods after the transfer edge
        logic       parOut;
    } vecT;

    vecT vecs[7];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs are sampled and inputs driven on the falling edge
    task automatic tick();
        @(negedge BaudOut);
    endtask

    task automatic drive(input logic [8:0] d, input logic [3:0] l, input logic [2:0] p,
                         input logic s, input logic snd);
        bus.data_in = d;
        bus.data_len = l;
        bus.parity_type = p;
        bus.stop_bits = s;
        bus.send = snd;
    endtask

    task automatic runFrame(input vecT v);
        logic [15:0] b;
        b = v.bits;
        check({v.name, " idle ready"}, {15'd0, bus.tx_ready}, 16'd1);
        drive(v.data, v.len, v.par, v.stop, 1'b1);
        tick();
        check({v.name, " accept ready"}, {15'd0, bus.tx_ready}, 16'd0);
        check({v.name, " accept line"}, {15'd0, bus.data_out}, 16'd1);
        // scramble inputs: config is frozen at accept
        drive(~v.data, 4'd0, 3'd2, ~v.stop, 1'b0);
        tick();
        check({v.name, " start line"}, {15'd0, bus.data_out}, 16'd0);
        check({v.name, " start active"}, {15'd0, bus.tx_active}, 16'd1);
        check({v.name, " start ready"}, {15'd0, bus.tx_ready}, 16'd1);
        check({v.name, " parity out"}, {15'd0, bus.p_parity_out}, {15'd0, v.parOut});
        for (int k = 1; k < v.flen; k++) begin
            tick();
            check($sformatf("%s bit%0d", v.name, k), {14'd0, bus.tx_done, bus.data_out},
                  {14'd0, 1'b0, b[k]});
            check($sformatf("%s active%0d", v.name, k), {15'd0, bus.tx_active}, 16'd1);
        end
        tick();
        check({v.name, " done"}, {12'd0, bus.tx_done, bus.data_out, bus.tx_active,
              bus.p_parity_out}, 16'b1100);
        tick();
        check({v.name, " done clears"}, {15'd0, bus.tx_done}, 16'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int doneCnt;
        logic [15:0] fa;
        logic [15:0] fb;
        checks = 0;
        errors = 0;
        vecs[0] = '{"8N1_4A",    9'h04A, 4'd8,  3'd0, 1'b0, 10, 16'h0294, 1'b0};
        vecs[1] = '{"7O2_4A",    9'h04A, 4'd7,  3'd1, 1'b1, 11, 16'h0694, 1'b0};
        vecs[2] = '{"9E1_1FF",   9'h1FF, 4'd9,  3'd2, 1'b0, 12, 16'h0FFE, 1'b1};
        vecs[3] = '{"len3_mark", 9'h1FF, 4'd3,  3'd3, 1'b0, 8,  16'h00FE, 1'b1};
        vecs[4] = '{"6S1_2C",    9'h02C, 4'd6,  3'd4, 1'b0, 9,  16'h0158, 1'b0};
        vecs[5] = '{"len15_p7",  9'h155, 4'd15, 3'd7, 1'b0, 11, 16'h06AA, 1'b0};
        vecs[6] = '{"5O1_mask",  9'h1E3, 4'd5,  3'd1, 1'b0, 8,  16'h00C6, 1'b1};

        // Reset held two cycles with send toggling
        rst = 1'b1;
        drive(9'h0AA, 4'd8, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("reset%0d", i), {11'd0, bus.data_out, bus.tx_active, bus.tx_done,
                  bus.tx_ready, bus.p_parity_out}, 16'b10010);
            bus.send = ~bus.send;
        end
        rst = 1'b0;
        bus.send = 1'b0;
        tick();
        check("post reset idle", {11'd0, bus.data_out, bus.tx_active, bus.tx_done,
              bus.tx_ready, bus.p_parity_out}, 16'b10010);

        foreach (vecs[i]) runFrame(vecs[i]);

        // Back-to-back: 8N1 0x4A then 8N1 0x35 queued during DATA
        fa = 16'h0294;
        fb = 16'h026A;
        doneCnt = 0;
        drive(9'h04A, 4'd8, 3'd0, 1'b0, 1'b1);
        tick();
        bus.send = 1'b0;
        tick();                                  // c = 0: first start bit
        check("b2b start", {15'd0, bus.data_out}, 16'd0);
        for (int c = 1; c <= 21; c++) begin
            if (c == 2) drive(9'h035, 4'd8, 3'd0, 1'b0, 1'b1);
            if (c == 3) bus.send = 1'b0;
            tick();
            if (bus.tx_done === 1'b1) doneCnt++;
            if (c < 10) begin
                check($sformatf("b2b A bit%0d", c), {15'd0, bus.data_out}, {15'd0, fa[c]});
            end else if (c == 10) begin
                check("b2b seam", {13'd0, bus.tx_done, bus.data_out, bus.tx_active}, 16'b101);
                check("b2b seam ready", {15'd0, bus.tx_ready}, 16'd1);
            end else if (c < 20) begin
                check($sformatf("b2b B bit%0d", c - 10), {14'd0, bus.tx_done, bus.data_out},
                      {14'd0, 1'b0, fb[c-10]});
            end else if (c == 20) begin
                check("b2b end", {13'd0, bus.tx_done, bus.data_out, bus.tx_active}, 16'b110);
            end
            if (c == 4 || c == 9) begin
                check($sformatf("b2b queued ready%0d", c), {15'd0, bus.tx_ready}, 16'd0);
            end
            if (c < 20) begin
                check($sformatf("b2b active%0d", c), {15'd0, bus.tx_active}, 16'd1);
            end
        end
        check("b2b done count", 16'(doneCnt), 16'd2);

        // Reset at the 4th data bit with a frame queued
        drive(9'h04A, 4'd8, 3'd0, 1'b0, 1'b1);
        tick();
        bus.send = 1'b0;
        tick();                                  // c = 0: start bit
        for (int c = 1; c <= 4; c++) begin
            if (c == 1) drive(9'h0F0, 4'd8, 3'd0, 1'b0, 1'b1);
            if (c == 2) bus.send = 1'b0;
            tick();
            if (c == 2) check("mid queued", {15'd0, bus.tx_ready}, 16'd0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid reset", {12'd0, bus.data_out, bus.tx_active, bus.tx_done, bus.tx_ready},
              16'b1001);
        doneCnt = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.tx_done !== 1'b0 || bus.data_out !== 1'b1) doneCnt++;
        end
        check("mid no queued frame", 16'(doneCnt), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
